// File: rtl/syscall_pkg.sv
`default_nettype none
// ============================================================================
// Module      : syscall_pkg
// Description : Shared constants, FSM state encoding and sysreg field layout
//               for the syscall sequencer and its request queue.
// Revision    : 1.0 - initial release
// ============================================================================
package syscall_pkg;

  // Field geometry of the 48-bit call register {arg2, arg1, code}
  localparam int unsigned FIELD_W         = 16;
  localparam int unsigned SYSREG_W        = 48;
  localparam int unsigned SYSREG_CODE_LSB = 0;
  localparam int unsigned SYSREG_ARG1_LSB = 16;
  localparam int unsigned SYSREG_ARG2_LSB = 32;

  // Syscall codes understood by the syscall unit
  localparam logic [FIELD_W-1:0] SYS_EXIT  = 16'd0;
  localparam logic [FIELD_W-1:0] SYS_STORE = 16'd1;
  localparam logic [FIELD_W-1:0] SYS_LOAD  = 16'd2;
  localparam logic [FIELD_W-1:0] SYS_PUTD  = 16'd3;
  localparam logic [FIELD_W-1:0] SYS_PUTC  = 16'd4;
  localparam logic [FIELD_W-1:0] SYS_PUTS  = 16'd5;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_RESP  = 3'd3,
    ST_HALT  = 3'd4
  } state_e;

  // Assemble a call register image from its three fields
  function automatic logic [SYSREG_W-1:0] pack_sysreg(
    input logic [FIELD_W-1:0] code,
    input logic [FIELD_W-1:0] arg1,
    input logic [FIELD_W-1:0] arg2
  );
    logic [SYSREG_W-1:0] r;
    r = '0;
    r[SYSREG_CODE_LSB +: FIELD_W] = code;
    r[SYSREG_ARG1_LSB +: FIELD_W] = arg1;
    r[SYSREG_ARG2_LSB +: FIELD_W] = arg2;
    return r;
  endfunction

  // Extract the code field of a call register image
  function automatic logic [FIELD_W-1:0] sysreg_code(input logic [SYSREG_W-1:0] r);
    return r[SYSREG_CODE_LSB +: FIELD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/syscall_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : syscall_req_fifo
// Description : Request queue for the syscall sequencer. Power-of-two depth,
//               wrapping read/write pointers plus an occupancy count, a
//               show-ahead head output and a synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_req_fifo #(
  parameter  int unsigned WIDTH = 48,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  // Occupancy flags and qualified handshakes; flush overrides both
  always_comb begin
    w_full    = (count_q == CNT_W'(DEPTH));
    w_empty   = (count_q == '0);
    w_do_push = push_i && !w_full && !flush_i;
    w_do_pop  = pop_i && !w_empty && !flush_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = w_full;
  assign empty_o   = w_empty;

endmodule
`default_nettype wire

// File: rtl/syscall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : syscall_sequencer
// Description : Queues CPU syscall requests and issues them one at a time to
//               the syscall unit as a one-cycle activate pulse with a stable
//               48-bit call register. Load calls return a response held
//               until the CPU accepts it; an exit call halts the block until
//               reset.
// Revision    : 1.0 - initial release
// ============================================================================
module syscall_sequencer
  import syscall_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [FIELD_W-1:0]  req_code,
  input  logic [FIELD_W-1:0]  req_arg1,
  input  logic [FIELD_W-1:0]  req_arg2,
  output logic                activate,
  output logic [SYSREG_W-1:0] sysreg,
  input  logic                load_signal,
  input  logic [FIELD_W-1:0]  load_data,
  output logic                rsp_valid,
  output logic [FIELD_W-1:0]  rsp_data,
  input  logic                rsp_ready,
  output logic                halted,
  output logic                busy
);

  state_e              state_q;
  logic                activate_q;
  logic [SYSREG_W-1:0] sysreg_q;
  logic                rsp_valid_q;
  logic [FIELD_W-1:0]  rsp_data_q;
  logic                halted_q;

  logic                w_push;
  logic                w_pop;
  logic                w_flush;
  logic                w_full;
  logic                w_empty;
  logic [SYSREG_W-1:0] w_head;
  logic [SYSREG_W-1:0] w_req_word;
  logic [FIELD_W-1:0]  w_cur_code;

  // Request acceptance: no space or a halted block both refuse new calls
  always_comb begin
    req_ready  = !w_full && !halted_q;
    w_push     = req_valid && req_ready;
    w_req_word = pack_sysreg(req_code, req_arg1, req_arg2);
    w_cur_code = sysreg_code(sysreg_q);
    w_flush    = (state_q == ST_HALT);
  end

  // Queue pop points: every transition into ISSUE consumes the head entry
  always_comb begin
    w_pop = 1'b0;
    case (state_q)
      ST_IDLE: w_pop = !w_empty;
      ST_GAP:  w_pop = !w_empty && (w_cur_code != SYS_EXIT) && (w_cur_code != SYS_LOAD);
      ST_RESP: w_pop = !w_empty && rsp_ready;
      default: w_pop = 1'b0;
    endcase
  end

  syscall_req_fifo #(
    .WIDTH (SYSREG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (w_push),
    .wr_data_i (w_req_word),
    .pop_i     (w_pop),
    .rd_data_o (w_head),
    .flush_i   (w_flush),
    .full_o    (w_full),
    .empty_o   (w_empty)
  );

  // Sequencer FSM with registered trigger, call register and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      activate_q  <= 1'b0;
      sysreg_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      halted_q    <= 1'b0;
    end else begin
      // activate is only ever raised for the single cycle spent in ISSUE
      activate_q <= 1'b0;
      if (w_pop) sysreg_q <= w_head;

      case (state_q)
        ST_IDLE: begin
          if (w_pop) begin
            state_q    <= ST_ISSUE;
            activate_q <= 1'b1;
          end
        end

        ST_ISSUE: begin
          state_q <= ST_GAP;
        end

        ST_GAP: begin
          if (w_cur_code == SYS_LOAD) begin
            // A load without a valid flag from the unit returns zero
            rsp_data_q  <= load_signal ? load_data : '0;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else if (w_cur_code == SYS_EXIT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALT;
          end else if (w_pop) begin
            state_q    <= ST_ISSUE;
            activate_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (w_pop) begin
              state_q    <= ST_ISSUE;
              activate_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        ST_HALT: begin
          state_q <= ST_HALT;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign activate  = activate_q;
  assign sysreg    = sysreg_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign halted    = halted_q;
  assign busy      = (state_q != ST_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_syscall_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_syscall_sequencer
// Description : Self-checking bench for syscall_sequencer with a behavioural
//               syscall unit (byte-addressed memory) and a request-list
//               reference model for randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_syscall_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_code;
  logic [15:0] req_arg1;
  logic [15:0] req_arg2;
  logic        activate;
  logic [47:0] sysreg;
  logic        load_signal;
  logic [15:0] load_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        halted;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  syscall_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_code    (req_code),
    .req_arg1    (req_arg1),
    .req_arg2    (req_arg2),
    .activate    (activate),
    .sysreg      (sysreg),
    .load_signal (load_signal),
    .load_data   (load_data),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_ready   (rsp_ready),
    .halted      (halted),
    .busy        (busy)
  );

  // Syscall unit: stores write memory on activate; loads read it back, and
  // report a valid load only when arg2 bit 0 is clear.
  logic [15:0] umem [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    if (rst_n && activate && sysreg[15:0] == 16'd1) umem[sysreg[23:16]] <= sysreg[47:32];
  end
  assign load_signal = (sysreg[15:0] == 16'd2) && !sysreg[32];
  assign load_data   = umem[sysreg[23:16]];

  // Monitor: records issued calls and accepted responses, checks protocol
  logic [47:0] obs_issue [$];
  logic [15:0] obs_rsp   [$];
  logic        prev_act = 1'b0;
  logic        prev_hold = 1'b0;
  logic [15:0] prev_rd = 16'h0;
  always begin
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (activate) begin
        obs_issue.push_back(sysreg);
        checks++;
        if (prev_act) begin
          errors++;
          $display("FAIL act_spacing: activate high on consecutive cycles, got 1 required 0");
        end
      end
      if (prev_hold) begin
        checks++;
        if (!rsp_valid || rsp_data !== prev_rd) begin
          errors++;
          $display("FAIL rsp_hold: got valid=%0b data=%h required valid=1 data=%h", rsp_valid, rsp_data, prev_rd);
        end
      end
      if (rsp_valid && rsp_ready) obs_rsp.push_back(rsp_data);
      prev_act  = activate;
      prev_hold = rsp_valid && !rsp_ready;
      prev_rd   = rsp_data;
    end else begin
      prev_act  = 1'b0;
      prev_hold = 1'b0;
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Drive one request from a negedge; returns one cycle after acceptance
  task automatic push(input logic [15:0] c, input logic [15:0] a1, input logic [15:0] a2,
                      input int bound, output bit ok);
    req_code  = c;
    req_arg1  = a1;
    req_arg2  = a2;
    req_valid = 1'b1;
    ok        = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (req_ready) begin
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    obs_issue.delete();
    obs_rsp.delete();
  endtask

  task automatic test_reset();
    req_valid = 1'b0; req_code = '0; req_arg1 = '0; req_arg2 = '0; rsp_ready = 1'b0;
    rst_n = 1'b0;
    tick(2);
    checks += 7;
    if (req_ready !== 1'b1)  begin errors++; $display("FAIL rst_req_ready: got %b required 1", req_ready); end
    if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    if (activate !== 1'b0)   begin errors++; $display("FAIL rst_activate: got %b required 0", activate); end
    if (sysreg !== 48'h0)    begin errors++; $display("FAIL rst_sysreg: got %h required 0", sysreg); end
    if (rsp_valid !== 1'b0)  begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
    if (rsp_data !== 16'h0)  begin errors++; $display("FAIL rst_rsp_data: got %h required 0", rsp_data); end
    if (halted !== 1'b0)     begin errors++; $display("FAIL rst_halted: got %b required 0", halted); end
    rst_n = 1'b1;
    tick(1);
    obs_issue.delete();
    obs_rsp.delete();
  endtask

  task automatic test_single_putd();
    bit ok;
    push(16'd3, 16'd42, 16'd0, 5, ok);
    checks += 6;
    if (!ok) begin errors++; $display("FAIL putd_accept: got ready never seen required accepted"); end
    if (activate !== 1'b0) begin errors++; $display("FAIL putd_act_t1: got %b required 0", activate); end
    tick(1);
    if (activate !== 1'b1) begin errors++; $display("FAIL putd_act_t2: got %b required 1", activate); end
    if (sysreg !== 48'h0000_002A_0003) begin errors++; $display("FAIL putd_sysreg: got %h required 00000002a0003", sysreg); end
    tick(1);
    if (activate !== 1'b0) begin errors++; $display("FAIL putd_act_t3: got %b required 0", activate); end
    tick(4);
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || obs_rsp.size() != 0) begin
      errors++; $display("FAIL putd_idle: got busy=%b rsp_valid=%b rsps=%0d required 0 0 0", busy, rsp_valid, obs_rsp.size());
    end
  endtask

  task automatic test_load_resp();
    bit ok1, ok2, seen;
    rsp_ready = 1'b0;
    push(16'd1, 16'h0010, 16'hBEEF, 5, ok1);
    push(16'd2, 16'h0010, 16'h0000, 5, ok2);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      tick(1);
    end
    checks += 2;
    if (!(ok1 && ok2 && seen)) begin errors++; $display("FAIL load_rsp_wait: got accepted=%b%b valid_seen=%b required 111", ok1, ok2, seen); end
    if (rsp_data !== 16'hBEEF) begin errors++; $display("FAIL load_rsp_data: got %h required beef", rsp_data); end
    tick(5);
    checks += 2;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF) begin
      errors++; $display("FAIL load_rsp_held: got valid=%b data=%h required 1 beef", rsp_valid, rsp_data);
    end
    if (activate !== 1'b0) begin errors++; $display("FAIL load_no_act: got %b required 0", activate); end
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    checks += 2;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL load_rsp_clear: got %b required 0", rsp_valid); end
    if (obs_rsp.size() != 1) begin errors++; $display("FAIL load_rsp_count: got %0d required 1", obs_rsp.size()); end
    tick(2);
    obs_issue.delete();
    obs_rsp.delete();
  endtask

  task automatic test_fifo_full();
    bit ok, seen;
    int accepted;
    logic [47:0] exp;
    rsp_ready = 1'b0;
    // Load with load_signal low stalls the block in RESP with a zero result
    push(16'd2, 16'h0030, 16'h0001, 5, ok);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin seen = 1'b1; break; end
      tick(1);
    end
    checks += 2;
    if (!(ok && seen)) begin errors++; $display("FAIL full_stall: got accepted=%b valid_seen=%b required 11", ok, seen); end
    if (rsp_data !== 16'h0000) begin errors++; $display("FAIL full_noload_data: got %h required 0000", rsp_data); end
    obs_issue.delete();
    accepted = 0;
    for (int k = 0; k < 5; k++) begin
      push(16'd3, 16'h0100 + 16'(k), 16'(k), 3, ok);
      if (ok) accepted++;
    end
    checks += 3;
    if (accepted != 4) begin errors++; $display("FAIL full_accept_count: got %0d required 4", accepted); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b required 0", req_ready); end
    if (rsp_valid !== 1'b1) begin errors++; $display("FAIL full_rsp_still: got %b required 1", rsp_valid); end
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    push(16'd3, 16'h0104, 16'd4, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL full_fifth_accept: got 0 required 1"); end
    for (int i = 0; i < 100 && busy; i++) tick(1);
    tick(1);
    checks++;
    if (obs_issue.size() != 5) begin errors++; $display("FAIL full_issue_count: got %0d required 5", obs_issue.size()); end
    for (int k = 0; k < 5 && k < obs_issue.size(); k++) begin
      exp = {16'(k), 16'h0100 + 16'(k), 16'd3};
      checks++;
      if (obs_issue[k] !== exp) begin errors++; $display("FAIL full_order_%0d: got %h required %h", k, obs_issue[k], exp); end
    end
  endtask

  task automatic test_halt();
    bit ok;
    int ready_leak;
    obs_issue.delete();
    push(16'd4, 16'h0041, 16'h0000, 5, ok);
    push(16'd0, 16'h0000, 16'h0000, 5, ok);
    push(16'd3, 16'h0007, 16'h0000, 5, ok);
    ready_leak = 0;
    for (int i = 0; i < 20; i++) begin
      if (halted && req_ready) ready_leak++;
      tick(1);
    end
    checks += 6;
    if (obs_issue.size() != 2) begin errors++; $display("FAIL halt_issue_count: got %0d required 2", obs_issue.size()); end
    else begin
      if (obs_issue[0] !== 48'h0000_0041_0004 || obs_issue[1] !== 48'h0) begin
        errors++; $display("FAIL halt_issue_vals: got %h %h required 000000410004 000000000000", obs_issue[0], obs_issue[1]);
      end
    end
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag: got %b required 1", halted); end
    if (req_ready !== 1'b0) begin errors++; $display("FAIL halt_ready: got %b required 0", req_ready); end
    if (ready_leak != 0) begin errors++; $display("FAIL halt_ready_leak: got %0d cycles required 0", ready_leak); end
    if (rsp_valid !== 1'b0 || activate !== 1'b0) begin
      errors++; $display("FAIL halt_outputs: got rsp_valid=%b activate=%b required 0 0", rsp_valid, activate);
    end
  endtask

  task automatic test_mid_reset();
    bit ok, seen;
    apply_reset();
    push(16'd3, 16'h0001, 16'h0000, 5, ok);
    push(16'd3, 16'h0002, 16'h0000, 5, ok);
    push(16'd3, 16'h0003, 16'h0000, 5, ok);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (activate) begin seen = 1'b1; break; end
      tick(1);
    end
    tick(1);
    rst_n = 1'b0;
    #1;
    checks += 7;
    if (!seen) begin errors++; $display("FAIL mrst_burst: got no activate required one"); end
    if (activate !== 1'b0)  begin errors++; $display("FAIL mrst_activate: got %b required 0", activate); end
    if (sysreg !== 48'h0)   begin errors++; $display("FAIL mrst_sysreg: got %h required 0", sysreg); end
    if (req_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b required 1", req_ready); end
    if (busy !== 1'b0)      begin errors++; $display("FAIL mrst_busy: got %b required 0", busy); end
    if (halted !== 1'b0)    begin errors++; $display("FAIL mrst_halted: got %b required 0", halted); end
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mrst_rsp_valid: got %b required 0", rsp_valid); end
    tick(2);
    rst_n = 1'b1;
    obs_issue.delete();
    tick(10);
    checks++;
    if (obs_issue.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL mrst_quiet: got %0d activates busy=%b required 0 0", obs_issue.size(), busy);
    end
  endtask

  logic [47:0] exp_issue [$];
  bit          rnd_done;

  task automatic test_random();
    logic [15:0] model_mem [8];
    logic [15:0] exp_rsp [$];
    logic [15:0] c, a1, a2, e;
    bit ok;
    apply_reset();
    exp_issue.delete();
    for (int i = 0; i < 8; i++) model_mem[i] = 16'h0;
    rnd_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          tick($urandom_range(0, 2));
          c  = 16'($urandom_range(1, 9));
          a1 = 16'h0020 + 16'($urandom_range(0, 7));
          a2 = 16'($urandom);
          push(c, a1, a2, 200, ok);
          if (ok) exp_issue.push_back({a2, a1, c});
          else begin errors++; $display("FAIL rnd_accept_%0d: got timeout required accepted", n); end
        end
        for (int i = 0; i < 2000 && busy; i++) tick(1);
        tick(1);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          rsp_ready = 1'($urandom_range(0, 1));
          tick(1);
        end
        rsp_ready = 1'b0;
      end
    join
    // Reference: calls execute strictly in acceptance order
    foreach (exp_issue[k]) begin
      if (exp_issue[k][15:0] == 16'd1) model_mem[exp_issue[k][18:16]] = exp_issue[k][47:32];
      if (exp_issue[k][15:0] == 16'd2) exp_rsp.push_back(exp_issue[k][32] ? 16'h0 : model_mem[exp_issue[k][18:16]]);
    end
    checks += 2;
    if (obs_issue.size() != exp_issue.size()) begin
      errors++; $display("FAIL rnd_issue_count: got %0d required %0d", obs_issue.size(), exp_issue.size());
    end
    if (obs_rsp.size() != exp_rsp.size()) begin
      errors++; $display("FAIL rnd_rsp_count: got %0d required %0d", obs_rsp.size(), exp_rsp.size());
    end
    for (int k = 0; k < exp_issue.size() && k < obs_issue.size(); k++) begin
      checks++;
      if (obs_issue[k] !== exp_issue[k]) begin errors++; $display("FAIL rnd_issue_%0d: got %h required %h", k, obs_issue[k], exp_issue[k]); end
    end
    for (int k = 0; k < exp_rsp.size() && k < obs_rsp.size(); k++) begin
      e = exp_rsp[k];
      checks++;
      if (obs_rsp[k] !== e) begin errors++; $display("FAIL rnd_rsp_%0d: got %h required %h", k, obs_rsp[k], e); end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_putd();
    test_load_resp();
    test_fifo_full();
    test_halt();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/syscall_sequencer.md
SYSCALL_SEQUENCER -- requirements
Module: syscall_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, sets the request queue depth; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  in  1  is the asynchronous active-low reset.
REQ-005 Port req_valid  in  1  SHALL indicate that the CPU presents a syscall request.
REQ-006 Port req_ready  out  1  SHALL indicate that the request queue accepts a request.
REQ-007 Port req_code  in  16  SHALL carry the syscall code.
REQ-008 Port req_arg1  in  16  SHALL carry the first argument (address or value).
REQ-009 Port req_arg2  in  16  SHALL carry the second argument (store data).
REQ-010 Port activate  out  1  SHALL be the edge-triggered trigger to the syscall unit.
REQ-011 Port sysreg  out  48  SHALL be {arg2, arg1, code}, with code in bits [15:0].
REQ-012 Port load_signal  in  1  SHALL be the load-valid flag returned by the syscall unit.
REQ-013 Port load_data  in  16  SHALL be the load result returned by the syscall unit.
REQ-014 Port rsp_valid  out  1  SHALL indicate that load response data is valid.
REQ-015 Port rsp_data  out  16  SHALL carry the load response data.
REQ-016 Port rsp_ready  in  1  SHALL indicate that the CPU accepts the response.
REQ-017 Port halted  out  1  SHALL be a sticky flag, set once an exit code (0) has been issued.
REQ-018 Port busy  out  1  SHALL be high whenever the state is not IDLE or the queue is non-empty.

Function
REQ-019 A request SHALL be pushed on a clock edge where req_valid and req_ready are both high; arguments SHALL be captured unmodified.
REQ-020 req_ready SHALL equal (not full) AND (not halted); there SHALL be no same-cycle bypass when the queue is full.
REQ-021 The queue SHALL use wrapping read/write pointers plus a count; a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-022 The FSM states SHALL be IDLE, ISSUE, GAP, RESP and HALT.
REQ-023 In IDLE with the queue non-empty: pop the head, load sysreg, and go to ISSUE on the next edge.
REQ-024 In ISSUE: activate=1 for exactly one cycle, with sysreg stable; the next state is GAP.
REQ-025 In GAP: activate=0 and sysreg held; on exit, code 2 SHALL capture load_data into rsp_data and go to RESP; code 0 SHALL go to HALT; any other code SHALL go to ISSUE with the next entry popped if the queue is non-empty, else to IDLE.
REQ-026 Code 2 SHALL capture load_data only if load_signal=1; otherwise rsp_data SHALL be 16'h0000.
REQ-027 In RESP: rsp_valid=1 and rsp_data stable until rsp_ready=1; on that edge go to IDLE, or directly to ISSUE with a pop if the queue is non-empty.
REQ-028 Back-to-back non-load calls SHALL issue every 2 cycles (activate pattern 1,0,1,0); activate SHALL never be high on two consecutive cycles.
REQ-029 In HALT: halted=1 and the queue is flushed (count=0); req_ready=0, activate=0 and rsp_valid=0 until reset.
REQ-030 Codes greater than 5 SHALL be issued like codes 1, 3, 4 and 5, with no response.
REQ-031 sysreg SHALL hold its last issued value in IDLE and HALT.

Reset
REQ-032 On rst_n=0, asynchronously: state=IDLE, count and pointers 0, activate=0, sysreg=0, rsp_valid=0, rsp_data=0, halted=0; req_ready=1 and busy=0 once the reset state is established.
REQ-033 A reset mid-operation (any state) SHALL abandon the in-flight call and discard queued entries, with no further activate edge.
REQ-034 Reset release SHALL take effect on the first clk rising edge after rst_n rises.

Structure
REQ-035 Package syscall_pkg SHALL hold the code constants SYS_EXIT=0, SYS_STORE=1, SYS_LOAD=2, SYS_PUTD=3, SYS_PUTC=4, SYS_PUTS=5, the FSM state enum, and the 48-bit sysreg field offsets.
REQ-036 The queue SHALL be the sub-module syscall_req_fifo (width 48, depth FIFO_DEPTH); the FSM and response register SHALL live in syscall_sequencer.

Verification
REQ-037 Push {code=3, arg1=42} into an idle block -> activate high exactly 2 cycles after acceptance for one cycle, sysreg=48'h0000_002A_0003, no rsp_valid.
REQ-038 Push {1, 16'h0010, 16'hBEEF} then {2, 16'h0010, 0}; the model returns load_signal=1 and load_data=16'hBEEF -> rsp_valid with rsp_data=16'hBEEF, held while rsp_ready=0 for 5 cycles, cleared the cycle after rsp_ready=1.
REQ-039 Push 5 requests back-to-back with FIFO_DEPTH=4 while the block is stalled in RESP -> req_ready=0 at count 4, no entry lost or duplicated, issue order preserved.
REQ-040 Push {4,'A'}, {0}, {3,7} -> two activate pulses only; halted=1; req_ready stays 0; the third request is never issued.
REQ-041 Assert rst_n=0 during GAP of a queued 3-call burst -> all outputs at reset values immediately; after release, no activate until a new push.
